// File: rtl/cosine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cosine_pkg : fixed-point widths, angle constants and CORDIC atan table
// Rev 1.0
// ----------------------------------------------------------------------------
package cosine_pkg;

   localparam int FIX_W = 38;  // Q8.30 unsigned angle after unpack
   localparam int RED_W = 42;  // Q8.34 unsigned, extra guard bits for reduction
   localparam int CW    = 32;  // CORDIC datapath, signed Q2.30
   localparam int ITERS = 24;

   localparam logic [CW-1:0]    K_Q30             = 32'h26DD3B6A;
   localparam logic [CW-1:0]    ONE_Q30           = 32'h40000000;
   localparam logic [RED_W-1:0] HALF_PI_Q34       = 42'd26986075409;
   localparam logic [RED_W-1:0] PI_Q34            = 42'd53972150818;
   localparam logic [RED_W-1:0] THREE_HALF_PI_Q34 = 42'd80958226227;
   localparam logic [RED_W-1:0] TWO_PI_Q34        = 42'd107944301636;
   localparam logic [31:0]      F32_NAN           = 32'h7FC00000;

   typedef struct packed {
      logic             valid;
      logic             nan;
      logic [FIX_W-1:0] fix;
   } s1_t;

   typedef struct packed {
      logic          valid;
      logic          nan;
      logic          neg;
      logic [CW-1:0] z;
   } s2_t;

   typedef struct packed {
      logic          valid;
      logic          nan;
      logic          neg;
      logic [CW-1:0] x;
   } s3_t;

   // atan(2^-i) in Q2.30
   function automatic logic [CW-1:0] atan_q30(input int i);
      case (i)
         0:       atan_q30 = 32'h3243F6A8;
         1:       atan_q30 = 32'h1DAC6705;
         2:       atan_q30 = 32'h0FADBAFC;
         3:       atan_q30 = 32'h07F56EA6;
         4:       atan_q30 = 32'h03FEAB76;
         5:       atan_q30 = 32'h01FFD55B;
         6:       atan_q30 = 32'h00FFFAAA;
         7:       atan_q30 = 32'h007FFF55;
         8:       atan_q30 = 32'h003FFFEA;
         9:       atan_q30 = 32'h001FFFFD;
         10:      atan_q30 = 32'h000FFFFF;
         11:      atan_q30 = 32'h0007FFFF;
         12:      atan_q30 = 32'h0003FFFF;
         13:      atan_q30 = 32'h0001FFFF;
         14:      atan_q30 = 32'h0000FFFF;
         15:      atan_q30 = 32'h00007FFF;
         16:      atan_q30 = 32'h00003FFF;
         17:      atan_q30 = 32'h00001FFF;
         18:      atan_q30 = 32'h00000FFF;
         19:      atan_q30 = 32'h000007FF;
         20:      atan_q30 = 32'h000003FF;
         21:      atan_q30 = 32'h000001FF;
         22:      atan_q30 = 32'h000000FF;
         default: atan_q30 = 32'h0000007F;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/cosine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cosine_if : angle/result bus of the cosine pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
interface cosine_if;
   logic        clk_en;
   logic [31:0] angle;
   logic [31:0] result;

   modport master (output clk_en, output angle, input result);
   modport slave  (input clk_en, input angle, output result);
endinterface
`default_nettype wire

// File: rtl/cosine_cordic_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cosine_cordic_stage : one rotation-mode CORDIC shift-add micro-rotation
// Rev 1.0
// ----------------------------------------------------------------------------
module cosine_cordic_stage
   import cosine_pkg::*;
#(
   parameter int ITER = 0
) (
   input  wire logic signed [CW-1:0] x_i,
   input  wire logic signed [CW-1:0] y_i,
   input  wire logic signed [CW-1:0] z_i,
   output logic signed [CW-1:0]      x_o,
   output logic signed [CW-1:0]      y_o,
   output logic signed [CW-1:0]      z_o
);

   logic signed [CW-1:0] w_xs;
   logic signed [CW-1:0] w_ys;
   logic signed [CW-1:0] w_atan;
   logic                 w_pos;

   assign w_xs   = x_i >>> ITER;
   assign w_ys   = y_i >>> ITER;
   assign w_atan = $signed(atan_q30(ITER));
   assign w_pos  = ~z_i[CW-1];

   // Rotate toward z = 0: positive residual angle rotates counter-clockwise.
   assign x_o = w_pos ? (x_i - w_ys)   : (x_i + w_ys);
   assign y_o = w_pos ? (y_i + w_xs)   : (y_i - w_xs);
   assign z_o = w_pos ? (z_i - w_atan) : (z_i + w_atan);

endmodule
`default_nettype wire

// File: rtl/cosine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cosine : 4-stage pipelined single-precision cos() via range reduction + CORDIC
// Rev 1.0
// ----------------------------------------------------------------------------
module cosine
   import cosine_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        clk_en,
   input  wire logic [31:0] angle,
   output logic [31:0]      result
);

   s1_t         s1_d, s1_q;
   s2_t         s2_d, s2_q;
   s3_t         s3_d, s3_q;
   logic [31:0] result_d, result_q;

   // Stage 1: float -> Q8.30, sign ignored since cos is even
   logic [7:0]       w_exp;
   logic [FIX_W-1:0] w_mant;

   always_comb begin
      w_exp      = angle[30:23];
      w_mant     = {{(FIX_W-24){1'b0}}, 1'b1, angle[22:0]};
      s1_d       = '0;
      s1_d.valid = 1'b1;
      s1_d.nan   = (w_exp >= 8'd135);
      if (w_exp >= 8'd135 || w_exp < 8'd97)
         s1_d.fix = '0;
      else if (w_exp >= 8'd120)
         s1_d.fix = w_mant << (w_exp - 8'd120);
      else
         s1_d.fix = w_mant >> (8'd120 - w_exp);
   end

   // Stage 2: restoring mod-2pi reduction, then quadrant fold into [0, pi/2]
   logic [RED_W-1:0] w_rem;
   logic [RED_W-1:0] w_fold;
   logic [RED_W-1:0] w_zr;
   logic             w_neg;

   always_comb begin
      w_rem = {s1_q.fix, 4'b0000};
      for (int k = 5; k >= 0; k--) begin
         if (w_rem >= (TWO_PI_Q34 << k))
            w_rem = w_rem - (TWO_PI_Q34 << k);
      end
      if (w_rem < HALF_PI_Q34) begin
         w_fold = w_rem;
         w_neg  = 1'b0;
      end else if (w_rem < PI_Q34) begin
         w_fold = PI_Q34 - w_rem;
         w_neg  = 1'b1;
      end else if (w_rem < THREE_HALF_PI_Q34) begin
         w_fold = w_rem - PI_Q34;
         w_neg  = 1'b1;
      end else begin
         w_fold = TWO_PI_Q34 - w_rem;
         w_neg  = 1'b0;
      end
      w_zr       = w_fold + 42'd8;
      s2_d.valid = s1_q.valid;
      s2_d.nan   = s1_q.nan;
      s2_d.neg   = w_neg;
      s2_d.z     = w_zr[CW+3:4];
   end

   // Stage 3: unrolled CORDIC
   logic signed [CW-1:0] w_x [0:ITERS];
   logic signed [CW-1:0] w_y [0:ITERS];
   logic signed [CW-1:0] w_z [0:ITERS];

   assign w_x[0] = K_Q30;
   assign w_y[0] = '0;
   assign w_z[0] = s2_q.z;

   for (genvar i = 0; i < ITERS; i++) begin : g_cordic
      cosine_cordic_stage #(.ITER(i)) u_stage (
         .x_i (w_x[i]),
         .y_i (w_y[i]),
         .z_i (w_z[i]),
         .x_o (w_x[i+1]),
         .y_o (w_y[i+1]),
         .z_o (w_z[i+1])
      );
   end

   assign s3_d = '{valid: s2_q.valid, nan: s2_q.nan, neg: s2_q.neg, x: w_x[ITERS]};

   // Stage 4: sign-magnitude, saturate, normalise, round-to-nearest-even
   logic signed [CW-1:0] w_v;
   logic [CW-1:0]        w_mag;
   logic                 w_sgn;
   logic [4:0]           w_lead;
   logic [30:0]          w_norm;
   logic [24:0]          w_man;
   logic [7:0]           w_e;
   logic [31:0]          w_pack;

   always_comb begin
      w_v   = s3_q.neg ? -$signed(s3_q.x) : $signed(s3_q.x);
      w_sgn = w_v[CW-1];
      w_mag = w_sgn ? -w_v : w_v;
      if (w_mag > ONE_Q30)
         w_mag = ONE_Q30;
      w_lead = '0;
      for (int b = 0; b < 31; b++) begin
         if (w_mag[b])
            w_lead = b[4:0];
      end
      w_norm = w_mag[30:0] << (5'd30 - w_lead);
      w_man  = {2'b01, w_norm[29:7]}
             + {24'd0, w_norm[6] & (w_norm[7] | (|w_norm[5:0]))};
      w_e    = 8'd97 + {3'b000, w_lead} + {7'd0, w_man[24]};
      if (w_mag == '0)
         w_pack = '0;
      else
         w_pack = {w_sgn, w_e, (w_man[24] ? 23'd0 : w_man[22:0])};

      if (!s3_q.valid)
         result_d = '0;
      else if (s3_q.nan)
         result_d = F32_NAN;
      else
         result_d = w_pack;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         result_q <= '0;
      end else if (clk_en) begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

   logic w_unused;
   assign w_unused = ^{angle[31], w_y[ITERS], w_z[ITERS], w_zr[RED_W-1:CW+4],
                       w_zr[3:0], w_norm[30], w_man[23]};

endmodule
`default_nettype wire

// File: tb/tb_cosine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cosine : directed self-checking bench for the cosine pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cosine;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   localparam real TOL = 1.0 / 1048576.0;
   localparam int  NV  = 19;
   localparam int  NC  = 18;

   cosine_if u_if ();

   cosine dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (u_if.clk_en),
      .angle  (u_if.angle),
      .result (u_if.result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] vec_a [NV] = '{
      32'h3F800000, 32'h00000000, 32'h33800000, 32'h3F000000, 32'h42C80000,
      32'h43000000, 32'h7F800000, 32'h43800000, 32'hBF800000, 32'h40000000,
      32'h40400000, 32'h40800000, 32'h40A00000, 32'h437F0000, 32'h00000001,
      32'h7FC00000, 32'hC3800000, 32'h30800000, 32'h3FC90FDB};
   real vec_e [NV] = '{
      0.5403023058681398, 1.0, 1.0, 0.8775825618903728, 0.8623188722876839,
      -0.6928958218, 0.0, 0.0, 0.5403023058681398, -0.4161468365471424,
      -0.9899924966004454, -0.6536436208636119, 0.28366218546322625, -0.8623036078, 1.0,
      0.0, 0.0, 1.0, -0.0000000437113883};
   bit vec_n [NV] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   // Back-to-back stream: vector index and clk_en per cycle; NaN angle on idle cycles must be ignored
   int bb_idx [NC] = '{0, 3, 9, 10, 11, 6, 7, 7, 7, 12, 4, 5, 13, 8, 1, 1, 1, 1};
   bit bb_en  [NC] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0)
         return 0.0;
      if (f[30:23] == 8'hFF)
         return 1.0e30;
      d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic real fabs(input real a);
      return (a < 0.0) ? -a : a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      u_if.clk_en = 1'b1;
      u_if.angle  = 32'h3F800000;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (u_if.result !== 32'h0) begin
         errors++;
         $display("FAIL reset_async result=%h expected=%h", u_if.result, 32'h0);
      end
      repeat (2) tick();
      checks++;
      if (u_if.result !== 32'h0) begin
         errors++;
         $display("FAIL reset_held result=%h expected=%h", u_if.result, 32'h0);
      end
      #2 reset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if (e < 4) begin
            if (u_if.result !== 32'h0) begin
               errors++;
               $display("FAIL reset_release_edge%0d result=%h expected=%h", e, u_if.result, 32'h0);
            end
         end else if (fabs(f2r(u_if.result) - 0.5403023058681398) > TOL) begin
            errors++;
            $display("FAIL reset_first_result result=%h (%f) expected=%f", u_if.result,
                     f2r(u_if.result), 0.5403023058681398);
         end
      end
   endtask

   task automatic test_vectors();
      u_if.clk_en = 1'b1;
      for (int v = 0; v < NV; v++) begin
         u_if.angle = vec_a[v];
         repeat (4) tick();
         checks++;
         if (vec_n[v]) begin
            if (u_if.result !== 32'h7FC00000) begin
               errors++;
               $display("FAIL vec%0d angle=%h result=%h expected=%h", v, vec_a[v],
                        u_if.result, 32'h7FC00000);
            end
         end else if (u_if.result[30:23] == 8'hFF ||
                      fabs(f2r(u_if.result) - vec_e[v]) > TOL) begin
            errors++;
            $display("FAIL vec%0d angle=%h result=%h (%.9f) expected=%.9f", v, vec_a[v],
                     u_if.result, f2r(u_if.result), vec_e[v]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pipe [4];
      int n_en;
      int k;
      n_en = 0;
      pipe = '{0, 0, 0, 0};
      for (int c = 0; c < NC; c++) begin
         u_if.angle  = vec_a[bb_idx[c]];
         u_if.clk_en = bb_en[c];
         tick();
         if (bb_en[c]) begin
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = bb_idx[c];
            n_en++;
         end
         if (n_en >= 4) begin
            k = pipe[3];
            checks++;
            if (vec_n[k]) begin
               if (u_if.result !== 32'h7FC00000) begin
                  errors++;
                  $display("FAIL b2b_cycle%0d result=%h expected=%h", c, u_if.result, 32'h7FC00000);
               end
            end else if (u_if.result[30:23] == 8'hFF ||
                         fabs(f2r(u_if.result) - vec_e[k]) > TOL) begin
               errors++;
               $display("FAIL b2b_cycle%0d result=%h (%.9f) expected=%.9f", c, u_if.result,
                        f2r(u_if.result), vec_e[k]);
            end
         end
      end
      u_if.clk_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      u_if.clk_en = 1'b1;
      u_if.angle  = vec_a[4];
      tick();
      u_if.angle  = vec_a[5];
      tick();
      u_if.angle  = vec_a[9];
      tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (u_if.result !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_async result=%h expected=%h", u_if.result, 32'h0);
      end
      tick();
      checks++;
      if (u_if.result !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_held result=%h expected=%h", u_if.result, 32'h0);
      end
      #2 reset = 1'b1;
      u_if.angle = vec_a[3];
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if (e < 4) begin
            if (u_if.result !== 32'h0) begin
               errors++;
               $display("FAIL reset_mid_edge%0d result=%h expected=%h", e, u_if.result, 32'h0);
            end
         end else if (fabs(f2r(u_if.result) - 0.8775825618903728) > TOL) begin
            errors++;
            $display("FAIL reset_mid_first result=%h (%f) expected=%f", u_if.result,
                     f2r(u_if.result), 0.8775825618903728);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      u_if.clk_en = 1'b0;
      u_if.angle  = 32'h0;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
